// File: rtl/axi4_lite_pkg.sv
// AXI4-Lite shared definitions: response codes and the initiator FSM encoding.
// Reused by the slave-side wrappers.
package axi4_lite_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_WR_RESP,
      ST_RD_REQ,
      ST_RD_DATA
   } state_e;

   // SLVERR and DECERR both have the upper bit set
   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp[1];
   endfunction

endpackage

// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: one outstanding load/store from the core, mapped onto
// the AW/W/B and AR/R channels. All outputs registered except oREADY.
module axi4_lite_master
   import axi4_lite_pkg::*;
#(
   parameter int          ADDR_WIDTH = 32,
   parameter int          DATA_WIDTH = 32,
   parameter logic [2:0]  PROT       = 3'b000
) (
   input  logic                      iCLK,
   input  logic                      iRST,
   input  logic                      iREQ,
   input  logic                      iWE,
   input  logic [ADDR_WIDTH-1:0]     iADDR,
   input  logic [DATA_WIDTH-1:0]     iWDATA,
   input  logic [DATA_WIDTH/8-1:0]   iWSTRB,
   output logic                      oREADY,
   output logic                      oDONE,
   output logic [DATA_WIDTH-1:0]     oRDATA,
   output logic [1:0]                oRESP,
   output logic                      oERR,
   output logic                      m_AWVALID,
   input  logic                      m_AWREADY,
   output logic [ADDR_WIDTH-1:0]     m_AWADDR,
   output logic [2:0]                m_AWPROT,
   output logic                      m_WVALID,
   input  logic                      m_WREADY,
   output logic [DATA_WIDTH-1:0]     m_WDATA,
   output logic [DATA_WIDTH/8-1:0]   m_WSTRB,
   input  logic                      m_BVALID,
   output logic                      m_BREADY,
   input  logic [1:0]                m_BRESP,
   output logic                      m_ARVALID,
   input  logic                      m_ARREADY,
   output logic [ADDR_WIDTH-1:0]     m_ARADDR,
   output logic [2:0]                m_ARPROT,
   input  logic                      m_RVALID,
   output logic                      m_RREADY,
   input  logic [DATA_WIDTH-1:0]     m_RDATA,
   input  logic [1:0]                m_RRESP
);

   state_e                    state_q, state_d;
   logic                      awv_q, awv_d;
   logic                      wv_q, wv_d;
   logic                      bready_q, bready_d;
   logic                      arv_q, arv_d;
   logic                      rready_q, rready_d;
   logic                      aw_done_q, aw_done_d;
   logic                      w_done_q, w_done_d;
   logic                      done_q, done_d;
   logic                      err_q, err_d;
   logic [1:0]                resp_q, resp_d;
   logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
   logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state_q   <= ST_IDLE;
         awv_q     <= 1'b0;
         wv_q      <= 1'b0;
         bready_q  <= 1'b0;
         arv_q     <= 1'b0;
         rready_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         resp_q    <= '0;
         rdata_q   <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         state_q   <= state_d;
         awv_q     <= awv_d;
         wv_q      <= wv_d;
         bready_q  <= bready_d;
         arv_q     <= arv_d;
         rready_q  <= rready_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         done_q    <= done_d;
         err_q     <= err_d;
         resp_q    <= resp_d;
         rdata_q   <= rdata_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      awv_d     = awv_q;
      wv_d      = wv_q;
      bready_d  = bready_q;
      arv_d     = arv_q;
      rready_d  = rready_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      resp_d    = resp_q;
      rdata_d   = rdata_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      unique case (state_q)
         ST_IDLE: begin
            if (iREQ) begin
               addr_d = iADDR;
               if (iWE) begin
                  wdata_d   = iWDATA;
                  wstrb_d   = iWSTRB;
                  awv_d     = 1'b1;
                  wv_d      = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
                  state_d   = ST_WR_REQ;
               end else begin
                  arv_d   = 1'b1;
                  state_d = ST_RD_REQ;
               end
            end
         end
         ST_WR_REQ: begin
            if (awv_q && m_AWREADY) begin
               awv_d     = 1'b0;
               aw_done_d = 1'b1;
            end
            if (wv_q && m_WREADY) begin
               wv_d     = 1'b0;
               w_done_d = 1'b1;
            end
            // both channels may finish in the same cycle
            if (aw_done_d && w_done_d) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               bready_d  = 1'b1;
               state_d   = ST_WR_RESP;
            end
         end
         ST_WR_RESP: begin
            if (bready_q && m_BVALID) begin
               bready_d = 1'b0;
               resp_d   = m_BRESP;
               err_d    = resp_is_err(m_BRESP);
               done_d   = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         ST_RD_REQ: begin
            if (arv_q && m_ARREADY) begin
               arv_d    = 1'b0;
               rready_d = 1'b1;
               state_d  = ST_RD_DATA;
            end
         end
         ST_RD_DATA: begin
            if (rready_q && m_RVALID) begin
               rready_d = 1'b0;
               rdata_d  = m_RDATA;
               resp_d   = m_RRESP;
               err_d    = resp_is_err(m_RRESP);
               done_d   = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign oREADY    = (state_q == ST_IDLE);
   assign oDONE     = done_q;
   assign oERR      = err_q;
   assign oRESP     = resp_q;
   assign oRDATA    = rdata_q;
   assign m_AWVALID = awv_q;
   assign m_AWADDR  = addr_q;
   assign m_AWPROT  = PROT;
   assign m_WVALID  = wv_q;
   assign m_WDATA   = wdata_q;
   assign m_WSTRB   = wstrb_q;
   assign m_BREADY  = bready_q;
   assign m_ARVALID = arv_q;
   assign m_ARADDR  = addr_q;
   assign m_ARPROT  = PROT;
   assign m_RREADY  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: behavioural slave with per-transaction delays,
// table vectors, hand sequences and randomized transactions.
module tb_axi4_lite_master;

   logic        iCLK = 1'b0;
   logic        iRST = 1'b0;
   logic        iREQ = 1'b0;
   logic        iWE = 1'b0;
   logic [31:0] iADDR = '0;
   logic [31:0] iWDATA = '0;
   logic [3:0]  iWSTRB = '0;
   logic        oREADY, oDONE, oERR;
   logic [31:0] oRDATA;
   logic [1:0]  oRESP;
   logic        m_AWVALID, m_WVALID, m_BREADY, m_ARVALID, m_RREADY;
   logic [31:0] m_AWADDR, m_WDATA, m_ARADDR;
   logic [3:0]  m_WSTRB;
   logic [2:0]  m_AWPROT, m_ARPROT;
   logic        m_AWREADY = 1'b0;
   logic        m_WREADY = 1'b0;
   logic        m_BVALID = 1'b0;
   logic        m_ARREADY = 1'b0;
   logic        m_RVALID = 1'b0;
   logic [1:0]  m_BRESP = '0;
   logic [1:0]  m_RRESP = '0;
   logic [31:0] m_RDATA = '0;

   always #5 iCLK = ~iCLK;

   axi4_lite_master dut (
      .iCLK(iCLK), .iRST(iRST), .iREQ(iREQ), .iWE(iWE),
      .iADDR(iADDR), .iWDATA(iWDATA), .iWSTRB(iWSTRB),
      .oREADY(oREADY), .oDONE(oDONE), .oRDATA(oRDATA),
      .oRESP(oRESP), .oERR(oERR),
      .m_AWVALID(m_AWVALID), .m_AWREADY(m_AWREADY),
      .m_AWADDR(m_AWADDR), .m_AWPROT(m_AWPROT),
      .m_WVALID(m_WVALID), .m_WREADY(m_WREADY),
      .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB),
      .m_BVALID(m_BVALID), .m_BREADY(m_BREADY), .m_BRESP(m_BRESP),
      .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY),
      .m_ARADDR(m_ARADDR), .m_ARPROT(m_ARPROT),
      .m_RVALID(m_RVALID), .m_RREADY(m_RREADY),
      .m_RDATA(m_RDATA), .m_RRESP(m_RRESP)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          aw, w, b;
      logic        early;
      int          ar, r;
      logic [1:0]  resp;
      logic [31:0] rdata;
      int          exp_lat;
      logic [1:0]  exp_resp;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic hold_req = 1'b0;
   logic [31:0] last_rdata = '0;

   always @(posedge iCLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge iCLK);
      #2;
   endtask

   // slave configuration and state
   int          cfg_aw = 0, cfg_w = 0, cfg_b = 0, cfg_ar = 0, cfg_r = 0;
   logic        cfg_early = 1'b0;
   logic [1:0]  cfg_bresp = '0, cfg_rresp = '0;
   logic [31:0] cfg_rdata = '0;
   logic        spur_b = 1'b0, spur_r = 1'b0;
   logic        aw_got, w_got, ar_got, b_pend, r_pend;
   int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
   logic [31:0] s_addr, s_wdata, s_araddr;
   logic [3:0]  s_wstrb;
   int          s_bcnt = 0, s_rcnt = 0;
   logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
   logic        p_brdy, p_bpend, p_rrdy, p_rpend;
   logic [31:0] p_awaddr, p_wdata, p_araddr;
   logic [3:0]  p_wstrb;

   always begin
      @(posedge iCLK);
      #1;
      if (!iRST) begin
         {aw_got, w_got, ar_got, b_pend, r_pend} = '0;
         {aw_wait, w_wait, ar_wait, b_wait, r_wait} = '0;
         {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr} = '0;
         {p_brdy, p_bpend, p_rrdy, p_rpend} = '0;
         {m_AWREADY, m_WREADY, m_ARREADY, m_BVALID, m_RVALID} = '0;
      end else begin
         // protocol monitor: held while waiting, dropped after handshake
         if (p_awv && !p_awr) begin
            chk("aw_hold_valid", m_AWVALID, 1);
            chk("aw_hold_addr", m_AWADDR, p_awaddr);
         end
         if (p_awv && p_awr) chk("aw_drop", m_AWVALID, 0);
         if (p_wv && !p_wr) begin
            chk("w_hold_valid", m_WVALID, 1);
            chk("w_hold_data", m_WDATA, p_wdata);
            chk("w_hold_strb", m_WSTRB, p_wstrb);
         end
         if (p_wv && p_wr) chk("w_drop", m_WVALID, 0);
         if (p_arv && !p_arr) begin
            chk("ar_hold_valid", m_ARVALID, 1);
            chk("ar_hold_addr", m_ARADDR, p_araddr);
         end
         if (p_arv && p_arr) chk("ar_drop", m_ARVALID, 0);
         if (p_brdy && !p_bpend) chk("b_hold", m_BREADY, 1);
         if (p_brdy && p_bpend) chk("b_drop", m_BREADY, 0);
         if (p_rrdy && !p_rpend) chk("r_hold", m_RREADY, 1);
         if (p_rrdy && p_rpend) chk("r_drop", m_RREADY, 0);
         // handshakes completed at this edge
         if (p_awv && p_awr) begin aw_got = 1; s_addr = p_awaddr; end
         if (p_wv && p_wr) begin
            w_got = 1; s_wdata = p_wdata; s_wstrb = p_wstrb;
         end
         if (p_arv && p_arr) begin ar_got = 1; s_araddr = p_araddr; end
         if (p_bpend && p_brdy) begin
            b_pend = 0; aw_got = 0; w_got = 0; b_wait = 0; s_bcnt++;
         end
         if (p_rpend && p_rrdy) begin
            r_pend = 0; ar_got = 0; r_wait = 0; s_rcnt++;
         end
         // responses after their programmed delay
         if (!b_pend && aw_got && (w_got || cfg_early)) begin
            if (b_wait >= cfg_b) b_pend = 1;
            else b_wait++;
         end
         if (!r_pend && ar_got) begin
            if (r_wait >= cfg_r) r_pend = 1;
            else r_wait++;
         end
         m_AWREADY = m_AWVALID && (aw_wait >= cfg_aw);
         if (!m_AWVALID) aw_wait = 0; else if (!m_AWREADY) aw_wait++;
         m_WREADY = m_WVALID && (w_wait >= cfg_w);
         if (!m_WVALID) w_wait = 0; else if (!m_WREADY) w_wait++;
         m_ARREADY = m_ARVALID && (ar_wait >= cfg_ar);
         if (!m_ARVALID) ar_wait = 0; else if (!m_ARREADY) ar_wait++;
         m_BVALID = b_pend || spur_b;
         m_BRESP  = b_pend ? cfg_bresp : 2'b11;
         m_RVALID = r_pend || spur_r;
         m_RDATA  = r_pend ? cfg_rdata : 32'hBAD0_BAD0;
         m_RRESP  = r_pend ? cfg_rresp : 2'b11;
         p_awv = m_AWVALID; p_awr = m_AWREADY; p_awaddr = m_AWADDR;
         p_wv = m_WVALID; p_wr = m_WREADY;
         p_wdata = m_WDATA; p_wstrb = m_WSTRB;
         p_arv = m_ARVALID; p_arr = m_ARREADY; p_araddr = m_ARADDR;
         p_brdy = m_BREADY; p_bpend = b_pend;
         p_rrdy = m_RREADY; p_rpend = r_pend;
      end
   end

   // completion cycle relative to accept, from the channel delays
   function automatic int model_lat(input vec_t v);
      int hs, bs;
      if (!v.we) return 3 + v.ar + v.r;
      hs = (v.aw > v.w) ? v.aw : v.w;
      bs = v.early ? v.aw + v.b : hs + v.b;
      return 3 + ((hs > bs) ? hs : bs);
   endfunction

   function automatic vec_t mkv(
      input logic we, input logic [31:0] addr, input logic [31:0] wdata,
      input logic [3:0] wstrb, input int aw, input int w, input int b,
      input logic early, input int ar, input int r, input logic [1:0] resp,
      input logic [31:0] rdata, input int lat, input logic [1:0] eresp,
      input logic eerr, input logic [31:0] erdata);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
      v.aw = aw; v.w = w; v.b = b; v.early = early; v.ar = ar; v.r = r;
      v.resp = resp; v.rdata = rdata; v.exp_lat = lat;
      v.exp_resp = eresp; v.exp_err = eerr; v.exp_rdata = erdata;
      return v;
   endfunction

   task automatic start(input vec_t v, output int n);
      int guard = 0;
      while (!oREADY && guard < 60) begin tick; guard++; end
      chk("idle_ready", oREADY, 1);
      cfg_aw = v.aw; cfg_w = v.w; cfg_b = v.b; cfg_early = v.early;
      cfg_ar = v.ar; cfg_r = v.r;
      cfg_bresp = v.resp; cfg_rresp = v.resp; cfg_rdata = v.rdata;
      iREQ = 1; iWE = v.we; iADDR = v.addr;
      iWDATA = v.wdata; iWSTRB = v.wstrb;
      n = cyc;
      tick;
      if (!hold_req) iREQ = 0;
      chk("accept_busy", oREADY, 0);
   endtask

   task automatic finish(input vec_t v, input int n, output int d);
      int guard = 0;
      logic busy_ok = 1;
      int b0 = s_bcnt;
      int r0 = s_rcnt;
      while (!oDONE && guard < 60) begin
         if (oREADY) busy_ok = 0;
         tick;
         guard++;
      end
      d = cyc;
      chk("done_seen", oDONE, 1);
      if (oDONE) begin
         chk("latency", d - n, v.exp_lat);
         chk("ready_low_busy", busy_ok, 1);
         chk("ready_in_done", oREADY, 1);
         chk("resp", oRESP, v.exp_resp);
         chk("err", oERR, v.exp_err);
         chk("rdata", oRDATA, v.exp_rdata);
         if (v.we) begin
            chk("slv_awaddr", s_addr, v.addr);
            chk("slv_wdata", s_wdata, v.wdata);
            chk("slv_wstrb", s_wstrb, v.wstrb);
            chk("b_count", s_bcnt - b0, 1);
            chk("r_count_wr", s_rcnt - r0, 0);
         end else begin
            chk("slv_araddr", s_araddr, v.addr);
            chk("r_count", s_rcnt - r0, 1);
            chk("b_count_rd", s_bcnt - b0, 0);
         end
      end
   endtask

   task automatic run(input vec_t v);
      int n, d;
      hold_req = 0;
      start(v, n);
      finish(v, n, d);
      iREQ = 0;
      tick;
      chk("done_pulse", {oDONE, oERR}, 0);
   endtask

   vec_t vt[8];
   vec_t vw, vr, vx;
   int n1, d1, n2, d2;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = mkv(1, 32'h4000_0004, 32'hA5A5_0001, 4'hF, 0, 0, 1, 0, 0, 0,
                  2'b00, 32'h0, 4, 2'b00, 0, 32'h0);
      vt[1] = mkv(1, 32'h4000_0008, 32'h0000_1234, 4'h3, 3, 0, 1, 0, 0, 0,
                  2'b00, 32'h0, 7, 2'b00, 0, 32'h0);
      vt[2] = mkv(0, 32'h4000_0000, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2,
                  2'b00, 32'hDEAD_BEEF, 5, 2'b00, 0, 32'hDEAD_BEEF);
      vt[3] = mkv(0, 32'h4000_0010, 32'h0, 4'h0, 0, 0, 0, 0, 1, 1,
                  2'b10, 32'h0BAD_F00D, 5, 2'b10, 1, 32'h0BAD_F00D);
      vt[4] = mkv(1, 32'h4000_000C, 32'hCAFE_0000, 4'hC, 0, 2, 0, 0, 0, 0,
                  2'b11, 32'h0, 5, 2'b11, 1, 32'h0BAD_F00D);
      vt[5] = mkv(1, 32'h4000_0014, 32'h1122_3344, 4'h1, 1, 1, 0, 0, 0, 0,
                  2'b01, 32'h0, 4, 2'b01, 0, 32'h0BAD_F00D);
      vt[6] = mkv(1, 32'h4000_0018, 32'h5566_7788, 4'hF, 0, 3, 0, 1, 0, 0,
                  2'b00, 32'h0, 6, 2'b00, 0, 32'h0BAD_F00D);
      vt[7] = mkv(0, 32'h4000_001C, 32'h0, 4'h0, 0, 0, 0, 0, 2, 0,
                  2'b11, 32'h8765_4321, 5, 2'b11, 1, 32'h8765_4321);

      repeat (3) tick;
      chk("rst_ready", oREADY, 1);
      chk("rst_ctrl", {m_AWVALID, m_WVALID, m_BREADY, m_ARVALID,
                       m_RREADY, oDONE, oERR}, 0);
      chk("rst_rdata", oRDATA, 0);
      chk("rst_resp", oRESP, 0);
      chk("rst_addr", {m_AWADDR ^ m_ARADDR, m_AWADDR[0]}, 0);
      chk("rst_wdata", m_WDATA, 0);
      chk("rst_wstrb", m_WSTRB, 0);
      chk("prot", {m_AWPROT, m_ARPROT}, 0);
      iRST = 1;
      repeat (2) tick;

      for (int i = 0; i < 8; i++) run(vt[i]);
      last_rdata = 32'h8765_4321;

      // back-to-back with iREQ held high across both
      vw = mkv(1, 32'h4000_0020, 32'h0F0F_F0F0, 4'h6, 0, 0, 0, 0, 0, 0,
               2'b00, 32'h0, 3, 2'b00, 0, 32'h8765_4321);
      vr = mkv(0, 32'h4000_0024, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0,
               2'b00, 32'h1357_9BDF, 3, 2'b00, 0, 32'h1357_9BDF);
      hold_req = 1;
      start(vw, n1);
      finish(vw, n1, d1);
      hold_req = 0;
      start(vr, n2);
      chk("b2b_accept", n2, d1);
      finish(vr, n2, d2);
      iREQ = 0;
      tick;
      chk("b2b_pulse", {oDONE, oERR}, 0);
      last_rdata = 32'h1357_9BDF;

      // stray B/R while idle must not be consumed
      spur_b = 1; spur_r = 1;
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("spur_done", oDONE, 0);
         chk("spur_ready", {m_BREADY, m_RREADY}, 0);
      end
      spur_b = 0; spur_r = 0;
      tick;

      // async reset while waiting in WR_RESP
      vx = mkv(1, 32'h4000_0028, 32'h7777_0000, 4'hF, 0, 0, 20, 0, 0, 0,
               2'b00, 32'h0, 0, 2'b00, 0, 32'h0);
      start(vx, n1);
      for (int g = 0; g < 20 && !m_BREADY; g++) tick;
      chk("rst_in_wresp", m_BREADY, 1);
      #2;
      iRST = 0;
      #1;
      chk("arst_ctrl", {m_AWVALID, m_WVALID, m_BREADY, m_ARVALID,
                        m_RREADY, oDONE, oERR}, 0);
      chk("arst_ready", oREADY, 1);
      chk("arst_rdata", oRDATA, 0);
      chk("arst_addr", m_AWADDR, 0);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("arst_no_done", oDONE, 0);
      end
      iRST = 1;
      last_rdata = 0;
      tick;
      chk("arst_idle", oREADY, 1);

      // randomized traffic against the delay/latency model
      for (int i = 0; i < 40; i++) begin
         vec_t v;
         logic chain;
         v.we = 1'($urandom_range(0, 1));
         v.addr = $urandom() & 32'hFFFF_FFFC;
         v.wdata = $urandom();
         v.wstrb = 4'($urandom_range(0, 15));
         v.aw = $urandom_range(0, 3);
         v.w = $urandom_range(0, 3);
         v.b = $urandom_range(0, 3);
         v.early = v.we && ($urandom_range(0, 3) == 0);
         v.ar = $urandom_range(0, 3);
         v.r = $urandom_range(0, 3);
         v.resp = 2'($urandom_range(0, 3));
         v.rdata = $urandom();
         v.exp_lat = model_lat(v);
         v.exp_resp = v.resp;
         v.exp_err = v.resp[1];
         v.exp_rdata = v.we ? last_rdata : v.rdata;
         if (!v.we) last_rdata = v.rdata;
         chain = ($urandom_range(0, 2) == 0);
         hold_req = chain;
         start(v, n1);
         finish(v, n1, d1);
         iREQ = 0;
         if (!chain) begin
            tick;
            chk("rnd_pulse", {oDONE, oERR}, 0);
         end
      end
      hold_req = 0;
      iREQ = 0;
      repeat (2) tick;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
